// File: rtl/pkg_tpu.sv
// Shared types and constants for the TPU data-memory request path.
package pkg_tpu;

    localparam int ADDR_WIDTH = 12;
    localparam int NUM_REQ    = 2;

    typedef logic [ADDR_WIDTH-1:0] address_t;

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        BUSY,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer remembers which requester was served last.
module rr_arb2 (
    input  logic clock,
    input  logic reset,
    input  logic req1,
    input  logic req2,
    input  logic update,
    input  logic served,
    output logic valid,
    output logic idx
);

    // 0 = requester 1 served last, 1 = requester 2 served last
    logic last_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_reg <= 1'b1;
        end else if (update) begin
            last_reg <= served;
        end
    end

    always_comb begin
        valid = req1 | req2;
        idx   = 1'b0;
        if (req1 && req2) begin
            idx = ~last_reg;
        end else if (req2) begin
            idx = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_req_arbiter.sv
// Grants one of two requesters the memory port, strobes AGU configuration,
// counts data beats up to the latched length and releases with an end pulse.
module dmem_req_arbiter
    import pkg_tpu::*;
#(
    parameter int WIDTH_ADDR = ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Req1,
    input  logic                  I_Req2,
    input  logic [WIDTH_ADDR-1:0] I_Length1,
    input  logic [WIDTH_ADDR-1:0] I_Stride1,
    input  logic [WIDTH_ADDR-1:0] I_Base_Addr1,
    input  logic [WIDTH_ADDR-1:0] I_Length2,
    input  logic [WIDTH_ADDR-1:0] I_Stride2,
    input  logic [WIDTH_ADDR-1:0] I_Base_Addr2,
    input  logic                  I_Valid1,
    input  logic                  I_Valid2,
    output logic                  O_Grant1,
    output logic                  O_Grant2,
    output logic                  O_GrantVld,
    output logic                  O_GrantNo,
    output logic [WIDTH_ADDR-1:0] O_Length,
    output logic [WIDTH_ADDR-1:0] O_Stride,
    output logic [WIDTH_ADDR-1:0] O_Base_Addr,
    output logic                  O_Set_Config,
    output logic                  O_Beat,
    output logic                  O_End
);

    arb_state_t            state_reg, state_next;
    logic [WIDTH_ADDR-1:0] cnt_reg, cnt_next;
    logic [WIDTH_ADDR-1:0] length_reg, length_next;
    logic [WIDTH_ADDR-1:0] stride_reg, stride_next;
    logic [WIDTH_ADDR-1:0] base_reg, base_next;
    logic [NUM_REQ-1:0]    grant_reg, grant_next;
    logic                  grant_vld_reg, grant_vld_next;
    logic                  grant_no_reg, grant_no_next;
    logic                  owner_reg, owner_next;
    logic                  set_config_reg, set_config_next;

    logic                  pick_vld;
    logic                  pick_idx;
    logic                  rr_update;
    logic                  owner_valid;
    logic [WIDTH_ADDR-1:0] length_m1;

    rr_arb2 u_rr_arb2 (
        .clock  (clock),
        .reset  (reset),
        .req1   (I_Req1),
        .req2   (I_Req2),
        .update (rr_update),
        .served (owner_reg),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    // owner_reg survives the grant drop so RELEASE still knows who was served
    assign owner_valid = owner_reg ? I_Valid2 : I_Valid1;
    assign length_m1   = length_reg - WIDTH_ADDR'(1);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        length_next     = length_reg;
        stride_next     = stride_reg;
        base_next       = base_reg;
        grant_next      = grant_reg;
        grant_no_next   = grant_no_reg;
        owner_next      = owner_reg;
        set_config_next = 1'b0;
        rr_update       = 1'b0;
        O_Beat          = 1'b0;
        O_End           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_vld) begin
                    grant_next      = {pick_idx, ~pick_idx};
                    grant_no_next   = pick_idx;
                    owner_next      = pick_idx;
                    length_next     = pick_idx ? I_Length2    : I_Length1;
                    stride_next     = pick_idx ? I_Stride2    : I_Stride1;
                    base_next       = pick_idx ? I_Base_Addr2 : I_Base_Addr1;
                    set_config_next = 1'b1;
                    state_next      = CONFIG;
                end
            end
            CONFIG: begin
                if (length_reg == '0) begin
                    O_End         = 1'b1;
                    grant_next    = '0;
                    grant_no_next = 1'b0;
                    state_next    = RELEASE;
                end else begin
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (owner_valid) begin
                    O_Beat   = 1'b1;
                    cnt_next = cnt_reg + WIDTH_ADDR'(1);
                    if (cnt_reg == length_m1) begin
                        O_End         = 1'b1;
                        grant_next    = '0;
                        grant_no_next = 1'b0;
                        state_next    = RELEASE;
                    end
                end
            end
            RELEASE: begin
                rr_update  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        grant_vld_next = |grant_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            length_reg     <= '0;
            stride_reg     <= '0;
            base_reg       <= '0;
            grant_reg      <= '0;
            grant_vld_reg  <= 1'b0;
            grant_no_reg   <= 1'b0;
            owner_reg      <= 1'b0;
            set_config_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            length_reg     <= length_next;
            stride_reg     <= stride_next;
            base_reg       <= base_next;
            grant_reg      <= grant_next;
            grant_vld_reg  <= grant_vld_next;
            grant_no_reg   <= grant_no_next;
            owner_reg      <= owner_next;
            set_config_reg <= set_config_next;
        end
    end

    assign O_Grant1     = grant_reg[0];
    assign O_Grant2     = grant_reg[1];
    assign O_GrantVld   = grant_vld_reg;
    assign O_GrantNo    = grant_no_reg;
    assign O_Length     = length_reg;
    assign O_Stride     = stride_reg;
    assign O_Base_Addr  = base_reg;
    assign O_Set_Config = set_config_reg;

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Scoreboard bench for dmem_req_arbiter: a transaction-level model predicts
// each grant; a negedge monitor checks grants, beats, end pulses and gaps.
module tb_dmem_req_arbiter;

    logic        clock;
    logic        reset;
    logic        I_Req1, I_Req2;
    logic [11:0] I_Length1, I_Stride1, I_Base_Addr1;
    logic [11:0] I_Length2, I_Stride2, I_Base_Addr2;
    logic        I_Valid1, I_Valid2;
    logic        O_Grant1, O_Grant2, O_GrantVld, O_GrantNo;
    logic [11:0] O_Length, O_Stride, O_Base_Addr;
    logic        O_Set_Config, O_Beat, O_End;

    dmem_req_arbiter #(.WIDTH_ADDR(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req1       (I_Req1),
        .I_Req2       (I_Req2),
        .I_Length1    (I_Length1),
        .I_Stride1    (I_Stride1),
        .I_Base_Addr1 (I_Base_Addr1),
        .I_Length2    (I_Length2),
        .I_Stride2    (I_Stride2),
        .I_Base_Addr2 (I_Base_Addr2),
        .I_Valid1     (I_Valid1),
        .I_Valid2     (I_Valid2),
        .O_Grant1     (O_Grant1),
        .O_Grant2     (O_Grant2),
        .O_GrantVld   (O_GrantVld),
        .O_GrantNo    (O_GrantNo),
        .O_Length     (O_Length),
        .O_Stride     (O_Stride),
        .O_Base_Addr  (O_Base_Addr),
        .O_Set_Config (O_Set_Config),
        .O_Beat       (O_Beat),
        .O_End        (O_End)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          owner;
        logic [11:0] len;
        logic [11:0] str;
        logic [11:0] base;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   last_served = 2;   // 2 means requester 1 has priority
    int   txn_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no event, expected one within bound", what);
        finish_run();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant1"}, 32'(O_Grant1), 0);
        chk({tag, "_grant2"}, 32'(O_Grant2), 0);
        chk({tag, "_grantvld"}, 32'(O_GrantVld), 0);
        chk({tag, "_grantno"}, 32'(O_GrantNo), 0);
        chk({tag, "_length"}, 32'(O_Length), 0);
        chk({tag, "_stride"}, 32'(O_Stride), 0);
        chk({tag, "_base"}, 32'(O_Base_Addr), 0);
        chk({tag, "_setcfg"}, 32'(O_Set_Config), 0);
        chk({tag, "_beat"}, 32'(O_Beat), 0);
        chk({tag, "_end"}, 32'(O_End), 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit   in_acc = 0;
        bit   gap_valid = 0;
        int   gap_cnt = 0;
        int   beats = 0;
        bit   exp_beat, exp_end;
        exp_t cur;
        cur = '{owner: 0, len: 0, str: 0, base: 0};
        forever begin
            @(negedge clock);
            if (!reset) begin
                in_acc    = 0;
                gap_valid = 0;
                gap_cnt   = 0;
            end else begin
                chk("one_hot_grant", 32'(O_Grant1 & O_Grant2), 0);
                chk("grantvld_or", 32'(O_GrantVld), 32'(O_Grant1 | O_Grant2));
                if (!O_GrantVld) chk("grantno_idle", 32'(O_GrantNo), 0);
                if (O_Set_Config) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got set_config, expected none");
                    end else begin
                        cur = exp_q.pop_front();
                        txn_no++;
                        $display("txn %0d: grant to req%0d len=%0d stride=%0h base=%0h",
                                 txn_no, cur.owner, cur.len, cur.str, cur.base);
                        chk("grant_no", 32'(O_GrantNo), 32'(cur.owner - 1));
                        chk("grant1", 32'(O_Grant1), 32'(cur.owner == 1));
                        chk("grant2", 32'(O_Grant2), 32'(cur.owner == 2));
                        chk("length", 32'(O_Length), 32'(cur.len));
                        chk("stride", 32'(O_Stride), 32'(cur.str));
                        chk("base", 32'(O_Base_Addr), 32'(cur.base));
                        chk("config_beat", 32'(O_Beat), 0);
                        chk("config_end", 32'(O_End), 32'(cur.len == 0));
                        if (gap_valid) chk("grant_gap", gap_cnt, 2);
                        if (cur.len == 0) begin
                            in_acc    = 0;
                            gap_valid = 1;
                            gap_cnt   = 0;
                        end else begin
                            in_acc = 1;
                            beats  = 0;
                        end
                    end
                end else if (in_acc) begin
                    exp_beat = (cur.owner == 1) ? I_Valid1 : I_Valid2;
                    exp_end  = exp_beat && (beats == int'(cur.len) - 1);
                    chk("busy_grantvld", 32'(O_GrantVld), 1);
                    chk("busy_grantno", 32'(O_GrantNo), 32'(cur.owner - 1));
                    chk("busy_base", 32'(O_Base_Addr), 32'(cur.base));
                    chk("beat", 32'(O_Beat), 32'(exp_beat));
                    chk("end", 32'(O_End), 32'(exp_end));
                    if (exp_beat) beats++;
                    if (exp_end) begin
                        $display("txn %0d: end after %0d beats", txn_no, beats);
                        in_acc    = 0;
                        gap_valid = 1;
                        gap_cnt   = 0;
                    end
                end else begin
                    chk("idle_beat", 32'(O_Beat), 0);
                    chk("idle_end", 32'(O_End), 0);
                    if (!O_GrantVld) gap_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // mode 1: requester 1 only, 2: requester 2 only, 3: both
    task automatic do_round(input int mode,
                            input logic [11:0] l1, input logic [11:0] s1, input logic [11:0] b1,
                            input logic [11:0] l2, input logic [11:0] s2, input logic [11:0] b2,
                            input int pct);
        int   win;
        int   n;
        exp_t e;
        @(posedge clock);
        #1;
        I_Valid1 = 1'b0;
        I_Valid2 = 1'b0;
        I_Req1 = (mode != 2);
        I_Req2 = (mode != 1);
        I_Length1 = l1; I_Stride1 = s1; I_Base_Addr1 = b1;
        I_Length2 = l2; I_Stride2 = s2; I_Base_Addr2 = b2;
        if (mode == 3) win = (last_served == 1) ? 2 : 1;
        else win = mode;
        last_served = win;
        e.owner = win;
        e.len   = (win == 1) ? l1 : l2;
        e.str   = (win == 1) ? s1 : s2;
        e.base  = (win == 1) ? b1 : b2;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!O_Set_Config && n < 20);
        if (!O_Set_Config) timeout("set_config");
        if (!O_End) begin
            n = 0;
            do begin
                @(posedge clock);
                #1;
                I_Req1 = 1'b0;
                I_Req2 = 1'b0;
                I_Valid1 = (win == 1) ? ($urandom_range(0, 99) < pct) : 1'($urandom_range(0, 1));
                I_Valid2 = (win == 2) ? ($urandom_range(0, 99) < pct) : 1'($urandom_range(0, 1));
                @(negedge clock);
                n++;
            end while (!O_End && n < 20000);
            if (!O_End) timeout("end");
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b0;
        I_Req1 = 0; I_Req2 = 0; I_Valid1 = 0; I_Valid2 = 0;
        I_Length1 = 0; I_Stride1 = 0; I_Base_Addr1 = 0;
        I_Length2 = 0; I_Stride2 = 0; I_Base_Addr2 = 0;
        #3;
        check_all_zero("reset");
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        repeat (3) do_round(3, 12'd2, 12'd1, 12'h100, 12'd2, 12'd2, 12'h200, 100);
        do_round(1, 12'd4, 12'd1, 12'h010, 12'd7, 12'd3, 12'h333, 100);
        do_round(1, 12'd3, 12'd1, 12'h020, 12'd1, 12'd1, 12'h040, 40);
        do_round(2, 12'd5, 12'd1, 12'h050, 12'd0, 12'd4, 12'h060, 80);
        do_round(1, 12'd1, 12'd2, 12'h070, 12'd1, 12'd2, 12'h080, 60);
        do_round(3, 12'hFFF, 12'h7, 12'hABC, 12'd3, 12'd1, 12'h123, 100);
        for (int i = 0; i < 30; i++) begin
            do_round($urandom_range(1, 3),
                     12'($urandom_range(0, 6)), 12'($urandom), 12'($urandom),
                     12'($urandom_range(0, 6)), 12'($urandom), 12'($urandom),
                     $urandom_range(30, 100));
        end

        // abort an access after 2 of 5 beats
        @(posedge clock);
        #1;
        I_Valid1 = 0; I_Valid2 = 0;
        I_Req1 = 1; I_Req2 = 0;
        I_Length1 = 12'd5; I_Stride1 = 12'd1; I_Base_Addr1 = 12'h0F0;
        e = '{owner: 1, len: 12'd5, str: 12'd1, base: 12'h0F0};
        exp_q.push_back(e);
        last_served = 1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!O_Set_Config && n < 20);
        if (!O_Set_Config) timeout("abort_set_config");
        repeat (2) begin
            @(posedge clock);
            #1;
            I_Req1 = 0;
            I_Valid1 = 1;
        end
        @(posedge clock);
        #1;
        I_Valid1 = 0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        last_served = 2;
        do_round(3, 12'd2, 12'd1, 12'h111, 12'd2, 12'd1, 12'h222, 100);
        do_round(3, 12'd1, 12'd1, 12'h333, 12'd1, 12'd1, 12'h444, 100);

        repeat (3) @(posedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        finish_run();
    end

    initial begin
        #2000000;
        timeout("global");
    end

endmodule
